// File: rtl/hazard_pkg.sv
// Shared widths, constants and MD state encoding for the MIPS hazard controller.
package hazard_pkg;

   localparam int TUSE_W            = 2;
   localparam int REG_W             = 5;
   localparam int MULT_CYCLES_DEF   = 5;
   localparam int DIV_CYCLES_DEF    = 10;
   localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads the operation latency when a mult/div enters E,
// then counts down; md_busy covers the entry cycle plus the counted cycles.
module md_busy_cnt
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      md_start_e,
   input  logic      md_is_div_e,
   output logic      md_busy,
   output md_state_t md_state
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // State is a pure function of the count, so it can never disagree with it.
   always_comb begin
      md_state = (cnt_q == '0) ? MD_IDLE : MD_BUSY;
      cnt_d    = cnt_q;
      case (md_state)
         MD_IDLE: begin
            if (md_start_e) begin
               cnt_d = md_is_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
         end
         MD_BUSY: begin
            // A start arriving while busy is dropped; the running count continues.
            cnt_d = cnt_q - CNT_W'(1);
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = md_start_e | (md_state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: Tuse/Tnew data stalls plus optional mult/div busy stall.
// Define HAZARD_MDU_STALL_EN to build the mult/div busy counter; otherwise md_* inputs are ignored.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  rs_d,
   input  logic [REG_W-1:0]  rt_d,
   input  logic [TUSE_W-1:0] tuse_rs,
   input  logic [TUSE_W-1:0] tuse_rt,
   input  logic [REG_W-1:0]  wa_e,
   input  logic [TUSE_W-1:0] tnew_e,
   input  logic [REG_W-1:0]  wa_m,
   input  logic [TUSE_W-1:0] tnew_m,
   input  logic              md_use_d,
   input  logic              md_start_e,
   input  logic              md_is_div_e,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_clr,
   output logic              md_busy
);

   logic stall_rs;
   logic stall_rt;
   logic data_stall;
   logic md_busy_raw;
   logic md_stall;
   logic stall;

   // Register 0 is never a real dependency; Tnew 0 can never exceed Tuse, so it needs no special case.
   always_comb begin
      stall_rs = (rs_d != '0) && (tuse_rs != TUSE_NONE) &&
                 (((rs_d == wa_e) && (tuse_rs < tnew_e)) ||
                  ((rs_d == wa_m) && (tuse_rs < tnew_m)));
      stall_rt = (rt_d != '0) && (tuse_rt != TUSE_NONE) &&
                 (((rt_d == wa_e) && (tuse_rt < tnew_e)) ||
                  ((rt_d == wa_m) && (tuse_rt < tnew_m)));
      data_stall = stall_rs | stall_rt;
   end

`ifdef HAZARD_MDU_STALL_EN
   md_state_t md_state_unused;

   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_cnt (
      .clk         (clk),
      .reset       (reset),
      .md_start_e  (md_start_e),
      .md_is_div_e (md_is_div_e),
      .md_busy     (md_busy_raw),
      .md_state    (md_state_unused)
   );

   assign md_stall = md_use_d & md_busy_raw;
`else
   logic unused_md;

   assign unused_md   = ^{md_use_d, md_start_e, md_is_div_e,
                          CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
   assign md_busy_raw = 1'b0;
   assign md_stall    = 1'b0;
`endif

   // Outputs are held at their pass-through values for as long as reset is low.
   assign stall     = reset & (data_stall | md_stall);
   assign pc_en     = ~stall;
   assign if_id_en  = ~stall;
   assign id_ex_clr = stall;
   assign md_busy   = reset & md_busy_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: data-hazard vector table plus mult/div and reset sequences.
// Expectations for the mult/div unit follow whether HAZARD_MDU_STALL_EN is defined.
module tb_hazard_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
`ifdef HAZARD_MDU_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_d, rt_d, wa_e, wa_m;
   logic [1:0] tuse_rs, tuse_rt, tnew_e, tnew_m;
   logic       md_use_d, md_start_e, md_is_div_e;
   logic       pc_en, if_id_en, id_ex_clr, md_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rs_d        (rs_d),
      .rt_d        (rt_d),
      .tuse_rs     (tuse_rs),
      .tuse_rt     (tuse_rt),
      .wa_e        (wa_e),
      .tnew_e      (tnew_e),
      .wa_m        (wa_m),
      .tnew_m      (tnew_m),
      .md_use_d    (md_use_d),
      .md_start_e  (md_start_e),
      .md_is_div_e (md_is_div_e),
      .pc_en       (pc_en),
      .if_id_en    (if_id_en),
      .id_ex_clr   (id_ex_clr),
      .md_busy     (md_busy)
   );

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
      logic [4:0] wa_e;
      logic [1:0] tnew_e;
      logic [4:0] wa_m;
      logic [1:0] tnew_m;
      logic       stall;
   } vec_t;

   vec_t vecs[13];

   task automatic drive_quiet();
      rs_d = 5'd0; rt_d = 5'd0; tuse_rs = 2'd3; tuse_rt = 2'd3;
      wa_e = 5'd0; tnew_e = 2'd0; wa_m = 5'd0; tnew_m = 2'd0;
      md_use_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0;
   endtask

   task automatic drive_hazard();
      rs_d = 5'd8; tuse_rs = 2'd0; wa_e = 5'd8; tnew_e = 2'd2;
   endtask

   task automatic chk(input string tag, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic exp_stall, input logic exp_busy);
      chk({tag, ".pc_en"},     pc_en,     ~exp_stall);
      chk({tag, ".if_id_en"},  if_id_en,  ~exp_stall);
      chk({tag, ".id_ex_clr"}, id_ex_clr, exp_stall);
      chk({tag, ".md_busy"},   md_busy,   exp_busy);
   endtask

   initial begin
      //            rs    rt    tuse_rs tuse_rt wa_e  tnew_e wa_m  tnew_m stall
      vecs[0]  = '{5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1}; // load-use tuse 0
      vecs[1]  = '{5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1}; // tuse 1
      vecs[2]  = '{5'd8, 5'd0, 2'd2, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0}; // tuse 2 equals tnew
      vecs[3]  = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0}; // register 0
      vecs[4]  = '{5'd0, 5'd9, 2'd3, 2'd3, 5'd0, 2'd0, 5'd9, 2'd1, 1'b0}; // rt unused
      vecs[5]  = '{5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b1}; // M-stage rt hazard
      vecs[6]  = '{5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0}; // M released
      vecs[7]  = '{5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 2'd0, 5'd0, 2'd0, 1'b0}; // tnew_e 0
      vecs[8]  = '{5'd0, 5'd7, 2'd3, 2'd0, 5'd7, 2'd1, 5'd0, 2'd0, 1'b1}; // rt via E
      vecs[9]  = '{5'd3, 5'd0, 2'd0, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0}; // no match
      vecs[10] = '{5'd6, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd6, 2'd2, 1'b1}; // rs via M
      vecs[11] = '{5'd8, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0}; // rs unused
      vecs[12] = '{5'd4, 5'd4, 2'd3, 2'd1, 5'd0, 2'd0, 5'd4, 2'd1, 1'b0}; // rt tuse equals tnew_m

      // Reset with hazards and a mult/div start present: outputs must be forced.
      drive_quiet();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive_hazard();
         md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b1;
         #1 chk_outs($sformatf("rst_hold%0d", k), 1'b0, 1'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      drive_quiet();
      md_use_d = 1'b1;
      #1 chk_outs("rst_release", 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive_quiet();
         rs_d = vecs[i].rs; rt_d = vecs[i].rt;
         tuse_rs = vecs[i].tuse_rs; tuse_rt = vecs[i].tuse_rt;
         wa_e = vecs[i].wa_e; tnew_e = vecs[i].tnew_e;
         wa_m = vecs[i].wa_m; tnew_m = vecs[i].tnew_m;
         #1 chk_outs($sformatf("vec%0d", i), vecs[i].stall, 1'b0);
      end

      // Mult at cycle 0; a div start at cycle 3 lands in BUSY and must not extend the window.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive_quiet();
         md_use_d    = 1'b1;
         md_start_e  = (k == 0) || (k == 3);
         md_is_div_e = (k == 3);
         #1 chk_outs($sformatf("mult_c%0d", k), MD_EN && (k <= MULT_N), MD_EN && (k <= MULT_N));
      end

      // Div, data hazard overlapping the busy window, then reset at cycle 4.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_quiet();
         md_use_d    = 1'b1;
         md_start_e  = (k == 0);
         md_is_div_e = 1'b1;
         if (k == 2) drive_hazard();
         #1 chk_outs($sformatf("div_c%0d", k), MD_EN || (k == 2), MD_EN);
      end
      @(negedge clk);
      reset = 1'b0;
      drive_hazard();
      md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b1;
      #1 chk_outs("div_rst", 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      drive_quiet();
      md_use_d = 1'b1;
      #1 chk_outs("div_after_rst", 1'b0, 1'b0);

      // Fresh div: 11 busy cycles; md_use_d drops at cycle 5 so busy shows without a stall.
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         drive_quiet();
         md_use_d    = (k != 5);
         md_start_e  = (k == 0);
         md_is_div_e = 1'b1;
         #1 chk_outs($sformatf("div2_c%0d", k), MD_EN && (k <= DIV_N) && (k != 5),
                     MD_EN && (k <= DIV_N));
      end

      @(negedge clk);
      drive_quiet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
